// File: rtl/dsp_post_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsp_post_pkg: widths, X/Z select encodings, OPMODE bit positions           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dsp_post_pkg;

  localparam int c_P_WIDTH    = 48;
  localparam int c_M_WIDTH    = 36;
  localparam int c_IN_WIDTH   = 18;
  localparam int c_DAB_D_BITS = 12;

  localparam int c_OPM_X_LSB  = 0;
  localparam int c_OPM_Z_LSB  = 2;
  localparam int c_OPM_SUB    = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage : dsp_post_pkg
`default_nettype wire

// File: rtl/post_reg_mux_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | post_reg_mux_n: CE register with sync reset; output is register or bypass  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module post_reg_mux_n #(
  parameter int WIDTH = 48,
  parameter bit REG   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] r_q;

  // The register clocks in both modes so feedback never comes from o_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

  generate
    if (REG) begin : g_registered
      assign o_y = r_q;
    end else begin : g_bypass
      assign o_y = i_d;
    end
  endgenerate

endmodule : post_reg_mux_n
`default_nettype wire

// File: rtl/dsp_post_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsp_post_adder: X/Z mux, add/subtract with carry-in, P and carry registers |
// | Optional carry path: define DSP_POSTADD_CARRYOUT_EN                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dsp_post_adder
  import dsp_post_pkg::*;
#(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEP,
  input  logic                  CECARRYIN,
  input  logic [7:0]            OPMODE,
  input  logic [c_M_WIDTH-1:0]  M,
  input  logic [c_IN_WIDTH-1:0] D,
  input  logic [c_IN_WIDTH-1:0] A,
  input  logic [c_IN_WIDTH-1:0] B,
  input  logic [c_P_WIDTH-1:0]  C,
  input  logic [c_P_WIDTH-1:0]  PCIN,
  input  logic                  CIN,
  output logic [c_P_WIDTH-1:0]  P,
  output logic [c_P_WIDTH-1:0]  PCOUT,
  output logic                  CARRYOUT,
  output logic                  CARRYOUTF
);

  logic [c_P_WIDTH-1:0] w_x;
  logic [c_P_WIDTH-1:0] w_z;
  logic [c_P_WIDTH-1:0] w_dab;
  logic [c_P_WIDTH-1:0] w_res;
  logic [c_P_WIDTH-1:0] w_p_q;
  logic [c_P_WIDTH-1:0] w_p;
  logic                 w_sub;
  logic                 w_co;
  logic                 w_unused;

  assign w_dab    = {D[c_DAB_D_BITS-1:0], A, B};
  assign w_sub    = OPMODE[c_OPM_SUB];
  assign w_unused = &{1'b0, D[c_IN_WIDTH-1:c_DAB_D_BITS], OPMODE[6:4]};

  always_comb begin
    w_x = '0;
    case (x_sel_e'(OPMODE[c_OPM_X_LSB +: 2]))
      X_M:     w_x = {{(c_P_WIDTH - c_M_WIDTH){1'b0}}, M};
      X_P:     w_x = w_p_q;
      X_DAB:   w_x = w_dab;
      default: w_x = '0;
    endcase
  end

  always_comb begin
    w_z = '0;
    case (z_sel_e'(OPMODE[c_OPM_Z_LSB +: 2]))
      Z_PCIN:  w_z = PCIN;
      Z_P:     w_z = w_p_q;
      Z_C:     w_z = C;
      default: w_z = '0;
    endcase
  end

`ifdef DSP_POSTADD_CARRYOUT_EN
  logic [c_P_WIDTH:0] w_sum;
  logic               w_unused_co_q;

  // Bit 48 is carry on add and borrow on subtract.
  always_comb begin
    if (w_sub) begin
      w_sum = {1'b0, w_z} - ({1'b0, w_x} + {{c_P_WIDTH{1'b0}}, CIN});
    end else begin
      w_sum = {1'b0, w_z} + {1'b0, w_x} + {{c_P_WIDTH{1'b0}}, CIN};
    end
  end

  assign w_res = w_sum[c_P_WIDTH-1:0];

  post_reg_mux_n #(
    .WIDTH (1),
    .REG   (CARRYOUTREG != 0)
  ) u_carry_reg (
    .clk   (CLK),
    .rst   (RST),
    .i_ce  (CECARRYIN),
    .i_d   (w_sum[c_P_WIDTH]),
    .o_q   (w_unused_co_q),
    .o_y   (w_co)
  );
`else
  logic w_unused_carry;

  always_comb begin
    if (w_sub) begin
      w_res = w_z - (w_x + {{(c_P_WIDTH-1){1'b0}}, CIN});
    end else begin
      w_res = w_z + w_x + {{(c_P_WIDTH-1){1'b0}}, CIN};
    end
  end

  assign w_co           = 1'b0;
  assign w_unused_carry = CECARRYIN ^ (CARRYOUTREG != 0);
`endif

  post_reg_mux_n #(
    .WIDTH (c_P_WIDTH),
    .REG   (PREG != 0)
  ) u_p_reg (
    .clk   (CLK),
    .rst   (RST),
    .i_ce  (CEP),
    .i_d   (w_res),
    .o_q   (w_p_q),
    .o_y   (w_p)
  );

  assign P         = w_p;
  assign PCOUT     = w_p;
  assign CARRYOUT  = w_co;
  assign CARRYOUTF = w_co;

endmodule : dsp_post_adder
`default_nettype wire

// File: doc/dsp_post_adder.md
DSP_POST_ADDER -- requirements
Module: dsp_post_adder

Interface
REQ-001 The block SHALL have parameter PREG, default 1, meaning 1 = P output registered and 0 = P output combinational.
REQ-002 The block SHALL have parameter CARRYOUTREG, default 1, meaning 1 = CARRYOUT registered and 0 = CARRYOUT combinational.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all registers update on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port CEP, input, 1 bit, clock enable for the P register.
REQ-006 The block SHALL have port CECARRYIN, input, 1 bit, clock enable for the carry-out register.
REQ-007 The block SHALL have port OPMODE, input, 8 bits: [7] subtract, [3:2] Z select, [1:0] X select; other bits ignored.
REQ-008 The block SHALL have port M, input, 36 bits, multiplier product, zero-extended to 48 bits.
REQ-009 The block SHALL have ports D, A and B, each input, 18 bits; the concatenation of D[11:0], A and B forms the 48-bit DAB operand.
REQ-010 The block SHALL have ports C and PCIN, each input, 48 bits, the C operand and the cascade input.
REQ-011 The block SHALL have port CIN, input, 1 bit, carry-in from the CYI register stage.
REQ-012 The block SHALL have ports P and PCOUT, each output, 48 bits, the result; PCOUT is identical to P.
REQ-013 The block SHALL have ports CARRYOUT and CARRYOUTF, each output, 1 bit, carry/borrow; CARRYOUTF is identical to CARRYOUT.

Function
REQ-014 The X mux SHALL select by OPMODE[1:0]: 0 = zero, 1 = M zero-extended, 2 = internal P register, 3 = DAB.
REQ-015 The Z mux SHALL select by OPMODE[3:2]: 0 = zero, 1 = PCIN, 2 = internal P register, 3 = C.
REQ-016 With OPMODE[7]=0, the block SHALL compute the 49-bit sum {0,Z} + {0,X} + CIN.
REQ-017 With OPMODE[7]=1, the block SHALL compute the 49-bit difference {0,Z} - ({0,X} + CIN).
REQ-018 The result SHALL use bits [47:0] for P and bit [48] for carry-out; on overflow it wraps modulo 2^48, with no saturation.
REQ-019 The P feedback path SHALL always come from the internal P register, which clocks for both PREG values, so there is no combinational loop.
REQ-020 With PREG=1, P SHALL have 1-cycle latency from the inputs; with PREG=0, P SHALL equal the combinational result.
REQ-021 CARRYOUT latency SHALL follow REQ-020 using CARRYOUTREG.
REQ-022 With CEP=0, the P register SHALL hold; with CECARRYIN=0, the carry register SHALL hold; the two enables are independent.
REQ-023 When an accumulate is selected (X or Z = P) and CEP=0, the P register SHALL hold its value and SHALL NOT double-accumulate when CEP is re-asserted.

Reset
REQ-024 When RST=1 at a rising edge of CLK, the P register and the carry register SHALL clear to 0.
REQ-025 RST SHALL take priority over CEP and CECARRYIN.
REQ-026 After reset, P, PCOUT, CARRYOUT and CARRYOUTF SHALL read 0 when registered; when unregistered they SHALL reflect the combinational result computed with feedback = 0.
REQ-027 If reset is asserted mid-accumulation, the next cycle SHALL restart accumulation from 0, and no history SHALL be retained.

Configuration
REQ-028 The macro DSP_POSTADD_CARRYOUT_EN SHALL control the carry path: when defined, it compiles in the bit-48 carry logic and the carry register.
REQ-029 When DSP_POSTADD_CARRYOUT_EN is undefined, CARRYOUT and CARRYOUTF SHALL be constant 0, CECARRYIN SHALL be ignored, and the adder SHALL be 48 bits wide.

Structure
REQ-030 Package dsp_post_pkg SHALL hold the width constants (48, 36, 18) and the X/Z select encodings.
REQ-031 Package dsp_post_pkg SHALL hold the OPMODE bit positions.
REQ-032 A single parameterised sub-module, post_reg_mux_n (WIDTH, REG, sync reset, CE), SHALL be used for both the P register and the carry register.

Verification
REQ-033 The bench SHALL run PREG=1 with OPMODE=0x0D (Z=C, X=M, add), C=100, M=25, CIN=1 -> P=126 one cycle later and CARRYOUT=0.
REQ-034 The bench SHALL run OPMODE=0x8D (subtract) with C=10, M=20, CIN=0 -> P=0xFFFF_FFFF_FFF6 and CARRYOUT=1.
REQ-035 The bench SHALL run accumulation with OPMODE=0x09 (Z=P, X=M), M=5 and CEP=1 for 4 cycles -> P = 5, 10, 15, 20.
REQ-036 The bench SHALL deassert CEP for 2 cycles in that run -> P holds 20, and P=25 after re-enable.
REQ-037 The bench SHALL apply OPMODE=0x0D with C=0xFFFF_FFFF_FFFF, M=1, CIN=0 -> P=0 and CARRYOUT=1 (wrap).
REQ-038 The bench SHALL run with CARRYOUT_EN undefined -> CARRYOUT=0 throughout.
REQ-039 The bench SHALL assert RST with CEP=0 during accumulation (P=20) -> P=0 next edge, and accumulation with M=5 resumes at 5.
REQ-040 The bench SHALL run PREG=0, CARRYOUTREG=0 with OPMODE=0x03 (Z=0, X=DAB), D=0x001, A=0, B=0x00001 -> P=0x0010_0000_0001 in the same cycle.
